fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Parametrised instruction prefetch stage: next generation of the RV32I fetch path.
//  Owns the fetch PC and issues word reads to the synchronous instruction RAM port.
//  Buffers returned instructions with their PCs in a DEPTH-entry FIFO feeding the decoder.
//  Redirects on an EX-stage branch/jump flush, discarding queued and in-flight words.
// PARAMETERS
//  XLEN      32       address/PC width (>= 8)
//  DEPTH     4        FIFO entries; power of two, >= 2
//  RESET_PC  32'h34   PC of the first fetch after reset (bits [1:0] must be 0)
// PORTS
//  clk        in   1        clock, all state updates on rising edge
//  rst        in   1        asynchronous, active-high reset
//  flush      in   1        redirect request from exec (branch/jump taken)
//  flush_pc   in   XLEN     redirect target; bits [1:0] ignored (forced to 0)
//  mem_req    out  1        read issued this cycle
//  mem_addr   out  XLEN-2   word address = fetch_pc[XLEN-1:2]
//  mem_rdata  in   32       read data, valid the cycle after mem_req
//  de_stall   in   1        decoder cannot accept an instruction this cycle
//  insn_valid out  1        head entry present
//  insn       out  32       head instruction; 32'h00000013 (NOP) when empty
//  insn_pc    out  XLEN     head PC; 0 when empty
// BEHAVIOUR
//  State: fetch_pc (XLEN), inflight_q (1), inflight_pc (XLEN), FIFO storage of
//   DEPTH x {32, XLEN}, rd/wr pointers ($clog2(DEPTH) bits, natural wrap), count ($clog2(DEPTH)+1).
//  Reset (async): fetch_pc=RESET_PC, inflight_q=0, count=0, pointers=0.
//   Outputs during/after reset: mem_req=0, mem_addr=RESET_PC>>2, insn_valid=0, insn=NOP, insn_pc=0.
//  Issue: mem_req = !rst && !flush && (count + inflight_q) < DEPTH. Pops in the same
//   cycle do not add credit. On mem_req: fetch_pc += 4 (mod 2^XLEN),
//   inflight_q<=1, inflight_pc<=fetch_pc. Else inflight_q<=0.
//  Return: cycle after issue, if inflight_q && !flush, push {mem_rdata, inflight_pc}.
//   Credit rule guarantees push never occurs when full; overflow is a bug (assert).
//  Output: insn_valid = (count != 0); insn/insn_pc taken combinationally from head.
//   Pop when insn_valid && !de_stall. Push+pop same cycle: count unchanged.
//  Flush (highest priority): count<=0, rd_ptr<=wr_ptr, inflight_q<=0 (returning word
//   dropped), fetch_pc<={flush_pc[XLEN-1:2],2'b00}; no issue in flush cycle; pop in
//   flush cycle is ignored (decoder squashes its own copy).
//  Latencies: reset release/flush at edge t -> mem_req in cycle t (reset) / t+1 (flush),
//   data pushed at the following edge -> insn_valid next cycle. Steady state with
//   de_stall=0: one instruction per cycle, in PC order.
//  Flush during rst is ignored. Reset asserted mid-operation clears all state
//   immediately; no partial push survives.
// TESTING
//  T1 reset release, RAM[w]=w, de_stall=0 -> mem_addr 0x0D,0x0E,...; insn_valid from
//     2nd cycle, insn_pc 0x34,0x38,0x3C one per cycle, insn 0x0D,0x0E,0x0F.
//  T2 de_stall=1 held 10 cycles -> count reaches 4, mem_req low with count 4;
//     release -> 4 buffered insns drain in order, then fetch resumes gap-free.
//  T3 flush with flush_pc=0x101 while inflight_q=1 and count=3 -> insn_valid 0 next
//     cycle, in-flight word never appears, next valid insn_pc=0x100.
//  T4 flush coincident with push and pop -> count=0, rd_ptr==wr_ptr, no stale entry.
//  T5 flush_pc=0xFFFFFFFC -> insn_pc sequence 0xFFFFFFFC, 0x00000000, 0x00000004.
//  T6 assert rst asynchronously between edges at count=2 -> insn_valid, mem_req fall
//     without a clock edge; after release fetch restarts at 0x34.

Source files
------------

// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Brief    : RV32I instruction prefetch stage. Owns the fetch PC, issues word
//            reads to a synchronous instruction RAM and buffers returned
//            instructions with their PCs in a DEPTH-entry FIFO for decode.
//            An EX-stage flush redirects fetch and discards queued and
//            in-flight words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [XLEN-1:0]   flush_pc,
  output logic              mem_req,
  output logic [XLEN-3:0]   mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              de_stall,
  output logic              insn_valid,
  output logic [31:0]       insn,
  output logic [XLEN-1:0]   insn_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] c_DEPTH   = CNT_W'(DEPTH);
  localparam logic [31:0]      c_NOP     = 32'h0000_0013;
  localparam logic [XLEN-1:0]  c_PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0]  c_PC_MASK = ~XLEN'(3);

  // DEPTH must be a power of two so the pointers wrap naturally.
  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("fetch_queue: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]  fetch_pc_q,    fetch_pc_d;
  logic             inflight_q,    inflight_d;
  logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
  logic [CNT_W-1:0] count_q,       count_d;

  logic [31:0]      fifo_insn_q [DEPTH];
  logic [XLEN-1:0]  fifo_pc_q   [DEPTH];

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] w_credit_used;
  logic             w_mem_req;
  logic             w_push;
  logic             w_pop;
  logic             w_not_empty;

  // Credit counts buffered plus in-flight words; a pop this cycle does not
  // free a slot until the next cycle, which keeps the issue path short.
  assign w_credit_used = count_q + {{(CNT_W-1){1'b0}}, inflight_q};
  assign w_not_empty   = (count_q != '0);
  assign w_mem_req     = !rst && !flush && (w_credit_used < c_DEPTH);
  assign w_push        = inflight_q && !flush;
  // The decoder squashes its own copy on flush, so a flush-cycle pop is void.
  assign w_pop         = w_not_empty && !de_stall && !flush;

  // Next-state for fetch PC, in-flight tracking, pointers and occupancy.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (flush) begin
      // Redirect wins over everything: empty the FIFO and drop the returning word.
      fetch_pc_d = flush_pc & c_PC_MASK;
      inflight_d = 1'b0;
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
    end else begin
      if (w_mem_req) begin
        fetch_pc_d    = fetch_pc_q + c_PC_STEP;
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end else begin
        inflight_d    = 1'b0;
      end

      if (w_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage write; contents are qualified by count so need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_insn_q[wr_ptr_q] <= mem_rdata;
      fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_req    = w_mem_req;
  assign mem_addr   = fetch_pc_q[XLEN-1:2];
  assign insn_valid = w_not_empty;
  assign insn       = w_not_empty ? fifo_insn_q[rd_ptr_q] : c_NOP;
  assign insn_pc    = w_not_empty ? fifo_pc_q[rd_ptr_q]   : '0;

  // The issue credit must make a push into a full FIFO impossible.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (rst) w_push |-> (count_q != c_DEPTH)
  );

endmodule

`default_nettype wire
